// File: rtl/axi4_pkg.sv
// Shared AXI4 definitions: response codes and protection defaults.
// Used by every AXI initiator and target in the tree.
package axi4;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  function automatic logic is_okay(input logic [1:0] resp);
    return resp == OKAY;
  endfunction

endpackage

// File: rtl/axi_if.sv
// AXI4-Lite bundle with clock and reset.
// Ports: aclk, aresetn; modports master and slave.
interface axi #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic aclk,
  input logic aresetn
);
  logic          awvalid;
  logic          awready;
  logic [AW-1:0] awaddr;
  logic [2:0]    awprot;
  logic            wvalid;
  logic            wready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic       bvalid;
  logic       bready;
  logic [1:0] bresp;
  logic          arvalid;
  logic          arready;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;

  modport master (
    input  aclk, aresetn,
    input  awready, wready, bvalid, bresp,
    input  arready, rvalid, rdata, rresp,
    output awvalid, awaddr, awprot,
    output wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready
  );

  modport slave (
    input  aclk, aresetn,
    output awready, wready, bvalid, bresp,
    output arready, rvalid, rdata, rresp,
    input  awvalid, awaddr, awprot,
    input  wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready
  );
endinterface

// File: rtl/axi_master.sv
// Single-outstanding AXI4-Lite initiator bridging a CPU req/rsp port.
// Ports: bus (axi.master), req_* (CPU request), rsp_* (CPU response).
module axi_master #(
  parameter bit ALIGN_CHECK   = 1'b1,
  parameter bit WSTRB_ZERO_OK = 1'b0,
  parameter int DW            = 32
) (
  axi.master              bus,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [31:0]     req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic [DW/8-1:0] req_wstrb,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WADDR = 3'd1;
  localparam logic [2:0] S_WRESP = 3'd2;
  localparam logic [2:0] S_RADDR = 3'd3;
  localparam logic [2:0] S_RDATA = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;

  logic [2:0]      state;
  logic [31:0]     addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW/8-1:0] wstrb_q;
  logic            aw_done;
  logic            w_done;
  logic            aw_hs;
  logic            w_hs;
  logic            misaligned;
  logic            wstrb_skip;

  assign aw_hs = bus.awvalid && bus.awready;
  assign w_hs  = bus.wvalid && bus.wready;

  assign misaligned = ALIGN_CHECK && (req_addr[1:0] != 2'b00);
  assign wstrb_skip = req_we && !WSTRB_ZERO_OK
                   && (req_wstrb == '0);

  always_ff @(posedge bus.aclk) begin
    if (!bus.aresetn) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            if (misaligned) begin
              rsp_rdata <= '0;
              rsp_error <= 1'b1;
              state     <= S_RESP;
            end else if (wstrb_skip) begin
              rsp_rdata <= '0;
              rsp_error <= 1'b0;
              state     <= S_RESP;
            end else if (req_we) begin
              state <= S_WADDR;
            end else begin
              state <= S_RADDR;
            end
          end
        end
        S_WADDR: begin
          // aw and w may complete in any order; leave once both have.
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (bus.bvalid) begin
            rsp_rdata <= '0;
            rsp_error <= !axi4::is_okay(bus.bresp);
            state     <= S_RESP;
          end
        end
        S_RADDR: begin
          if (bus.arready) state <= S_RDATA;
        end
        S_RDATA: begin
          if (bus.rvalid) begin
            rsp_rdata <= bus.rdata;
            rsp_error <= !axi4::is_okay(bus.rresp);
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = bus.aresetn && (state == S_IDLE);
  assign rsp_valid   = (state == S_RESP);

  assign bus.awvalid = (state == S_WADDR) && !aw_done;
  assign bus.wvalid  = (state == S_WADDR) && !w_done;
  assign bus.bready  = (state == S_WRESP);
  assign bus.arvalid = (state == S_RADDR);
  // The memory target gates arready on rready, so raise both together.
  assign bus.rready  = (state == S_RADDR) || (state == S_RDATA);

  assign bus.awaddr  = addr_q;
  assign bus.araddr  = addr_q;
  assign bus.awprot  = axi4::PROT_DEFAULT;
  assign bus.arprot  = axi4::PROT_DEFAULT;
  assign bus.wdata   = wdata_q;
  assign bus.wstrb   = wstrb_q;

endmodule

// File: doc/axi_master.md
AXI_MASTER -- requirements
Module: axi_master

Interface
REQ-001 Parameter ALIGN_CHECK, default 1; 1 = a misaligned request is answered with an error and never issued on the bus.
REQ-002 Parameter WSTRB_ZERO_OK, default 0; 0 = a write with req_wstrb == 0 is answered OKAY without a bus transaction.
REQ-003 bus.aclk  input  1  sole clock; all logic on its rising edge; supplied by the axi interface.
REQ-004 bus.aresetn  input  1  reset, synchronous, active-low; supplied by the axi interface.
REQ-005 bus  axi.master  -  AXI4-Lite initiator port; data width is $bits(bus.wdata).
REQ-006 req_valid  input  1  the CPU presents a request.
REQ-007 req_ready  output  1  the block accepts a request.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  data width  write data.
REQ-011 req_wstrb  input  data width/8  write byte strobes.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  the CPU consumes the response.
REQ-014 rsp_rdata  output  data width  read data; 0 for writes.
REQ-015 rsp_error  output  1  1 = non-OKAY bus response, or misaligned request.

Function
REQ-016 At most one transaction outstanding; states IDLE, WADDR, WRESP, RADDR, RDATA, RESP.
REQ-017 IDLE: req_ready = 1, and only in IDLE. On req_valid & req_ready, latch addr/we/wdata/wstrb and go to WADDR (we = 1) or RADDR (we = 0).
REQ-018 Misaligned request with ALIGN_CHECK = 1 (req_addr[1:0] != 0): go to RESP with rsp_error = 1; no AXI channel is asserted.
REQ-019 Write with zero strobe and WSTRB_ZERO_OK = 0: go to RESP with rsp_error = 0; no bus activity.
REQ-020 WADDR: awvalid and wvalid rise together the cycle after acceptance. Each is held stable until its own handshake, independently.
REQ-021 WADDR exit: go to WRESP once both the aw and w handshakes are done, whether they complete in the same or different cycles.
REQ-022 WRESP: bready = 1. On bvalid, set rsp_error = (bresp != axi4::OKAY) and rsp_rdata = 0, then go to RESP.
REQ-023 RADDR: arvalid = 1 and rready = 1, because the memory slave gates arready on rready. On arready, go to RDATA.
REQ-024 RDATA: rready = 1. On rvalid, capture rdata to rsp_rdata, set rsp_error = (rresp != axi4::OKAY), and go to RESP.
REQ-025 RESP: rsp_valid = 1, with rsp_rdata and rsp_error held stable. On rsp_ready, go to IDLE.
REQ-026 The next request is accepted no earlier than the cycle after the response handshake.
REQ-027 awaddr/araddr = latched address; awprot/arprot = 0. The wdata/wstrb registers are driven only from the latch.
REQ-028 Latency with a zero-wait slave and rsp_ready held 1: read rsp_valid appears 3 cycles after acceptance; write rsp_valid appears 3 cycles after acceptance.
REQ-029 Outside their owning states, awvalid, wvalid, arvalid, bready, rready and rsp_valid are 0.
REQ-030 rvalid/bvalid arriving in any state other than the one that accepts it is not acknowledged.

Reset
REQ-031 While bus.aresetn = 0 at a clock edge, the following reset: state = IDLE; awvalid = wvalid = arvalid = bready = rready = 0; rsp_valid = 0; rsp_error = 0; rsp_rdata = 0.
REQ-032 Reset mid-transaction abandons it; no response is produced after reset.
REQ-033 req_ready = 0 during reset, and = 1 on the first cycle after deassertion.

Structure
REQ-034 Response codes come from the shared axi4 package.
REQ-035 The state enumeration is local to the module and is not in any package.
REQ-036 The block is a single module with no sub-module; one registered FSM plus latch registers.

Verification
REQ-037 Write then read: write 0xDEADBEEF to 0x10 with strobe 0xF, then read 0x10 -> rsp_rdata = 0xDEADBEEF, rsp_error = 0 on both.
REQ-038 Skewed channels: slave asserts wready 3 cycles before awready -> exactly one aw and one w handshake, and one bready handshake.
REQ-039 Error and misalignment: slave returns SLVERR on a read of 0x20 -> rsp_error = 1; read of 0x13 -> rsp_error = 1 with zero AXI valids.
REQ-040 Response backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_error stable and req_ready = 0 throughout.
REQ-041 Reset mid-operation: aresetn low for 1 cycle during RDATA -> all outputs at reset values, no rsp_valid, and the next read completes normally.
REQ-042 Back-to-back: 8 alternating write/read requests at consecutive addresses -> responses arrive in order with correct data.
